wb_load_store_unit: RTL and testbench

Writeback-stage load/store unit for the two-stage Skylark-V core; sits directly downstream of the EX/WB pipeline register and consumes its outputs (destination register, ALU result, store data, PC+4). Performs data-memory accesses over a request/grant/response handshake, aligns and extends load data, and drives the register-file write port. Holds the EX/WB register via `StallW` while a memory access is outstanding.

---
 rtl/skylark_lsu_pkg.sv | 21 ++
 rtl/lsu_data_align.sv | 50 +++++
 rtl/wb_load_store_unit.sv | 158 +++++++++++++++
 tb/tb_wb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/skylark_lsu_pkg.sv
// Shared types and encodings for the Skylark-V writeback load/store unit.
package skylark_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2,
        DONE        = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC  = 2'b10;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering for the load/store unit: byte enables, store
// replication, load extension and the misaligned/illegal-size flag.
module lsu_data_align
    import skylark_lsu_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] memAddr_o,
    output logic [3:0]  memBe_o,
    output logic [31:0] memWdata_o,
    output logic [31:0] loadData_o,
    output logic        bad_o
);

    logic [1:0]  offset;
    logic [31:0] shifted;

    assign offset    = addr_i[1:0];
    assign memAddr_o = {addr_i[31:2], 2'b00};
    // Bring the addressed lane down to bit 0 before extension.
    assign shifted   = rdata_i >> {offset, 3'b000};

    always_comb begin
        memBe_o    = 4'b0000;
        memWdata_o = storeData_i;
        loadData_o = rdata_i;
        bad_o      = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                memBe_o    = 4'b0001 << offset;
                memWdata_o = {4{storeData_i[7:0]}};
                loadData_o = {{24{(funct3_i == F3_B) & shifted[7]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                memBe_o    = 4'b0011 << {offset[1], 1'b0};
                memWdata_o = {2{storeData_i[15:0]}};
                loadData_o = {{16{(funct3_i == F3_H) & shifted[15]}}, shifted[15:0]};
                bad_o      = offset[0];
            end
            F3_W: begin
                memBe_o = 4'b1111;
                bad_o   = (offset != 2'b00);
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_load_store_unit.sv
// Writeback-stage load/store unit: runs the memory handshake, stalls the
// EX/WB register while an access is outstanding and drives the RF write port.
module wb_load_store_unit
    import skylark_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A3_W,
    input  logic [31:0] ALUResultW,
    input  logic [31:0] RD2_W,
    input  logic [31:0] PCNextW,
    input  logic        RegWriteW,
    input  logic        MemReadW,
    input  logic        MemWriteW,
    input  logic [2:0]  Funct3W,
    input  logic [1:0]  ResultSrcW,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        StallW,
    output logic        ErrW
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    logic [31:0] load_q, load_d;
    logic        err_q, err_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic        memOp, badAccess, timeoutHit;
    logic [31:0] loadData, aluOrPc;

    lsu_data_align u_align (
        .addr_i      (ALUResultW),
        .funct3_i    (Funct3W),
        .storeData_i (RD2_W),
        .rdata_i     (mem_rdata),
        .memAddr_o   (mem_addr),
        .memBe_o     (mem_be),
        .memWdata_o  (mem_wdata),
        .loadData_o  (loadData),
        .bad_o       (badAccess)
    );

    assign memOp      = MemReadW | MemWriteW;
    assign timeoutHit = (waitCnt_q == LAST_WAIT);
    assign aluOrPc    = (ResultSrcW == RS_PC) ? PCNextW : ALUResultW;
    assign rf_a3      = A3_W;
    assign mem_we     = mem_req & MemWriteW;

    // A handshake event in the last allowed wait cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (memOp && !badAccess) begin
                    if (mem_gnt) state_d = MemReadW ? WAIT_RVALID : DONE;
                    else         state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (mem_gnt) begin
                    state_d = MemReadW ? WAIT_RVALID : DONE;
                end else if (timeoutHit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            WAIT_RVALID: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                    load_d  = loadData;
                end else if (timeoutHit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            waitCnt_d = 8'd0;
        else if (state_q == WAIT_GNT || state_q == WAIT_RVALID)
            waitCnt_d = waitCnt_q + 8'd1;
        else
            waitCnt_d = waitCnt_q;
    end

    always_comb begin
        mem_req = 1'b0;
        StallW  = 1'b0;
        ErrW    = 1'b0;
        rf_we   = 1'b0;
        rf_wd   = aluOrPc;
        case (state_q)
            IDLE: begin
                if (memOp) begin
                    if (badAccess) begin
                        ErrW = 1'b1;
                    end else begin
                        mem_req = 1'b1;
                        StallW  = 1'b1;
                    end
                end else begin
                    rf_we = RegWriteW & (A3_W != 5'd0);
                end
            end
            WAIT_GNT: begin
                mem_req = 1'b1;
                StallW  = 1'b1;
            end
            WAIT_RVALID: StallW = 1'b1;
            DONE: begin
                ErrW  = err_q;
                rf_wd = load_q;
                rf_we = MemReadW & RegWriteW & (A3_W != 5'd0) & ~err_q;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req = 1'b0;
            StallW  = 1'b0;
            ErrW    = 1'b0;
            rf_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            load_q    <= 32'd0;
            err_q     <= 1'b0;
            waitCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            err_q     <= err_d;
            waitCnt_q <= waitCnt_d;
        end
    end

endmodule

// File: tb/tb_wb_load_store_unit.sv
// Self-checking bench for wb_load_store_unit: directed vector table, hand
// sequences for reset/ALU/error-pulse cases, and randomized transactions.
module tb_wb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  A3_W;
    logic [31:0] ALUResultW, RD2_W, PCNextW;
    logic        RegWriteW, MemReadW, MemWriteW;
    logic [2:0]  Funct3W;
    logic [1:0]  ResultSrcW;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        StallW, ErrW;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          isLoad;
        logic [4:0]  a3;
        logic [31:0] rdata;
        int          g;
        int          r;
        int          expStall;
        int          expReq;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        bit          expRfWe;
        logic [31:0] expRfWd;
        bit          expErr;
    } vec_t;

    vec_t vecs[15];

    wb_load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .A3_W       (A3_W),
        .ALUResultW (ALUResultW),
        .RD2_W      (RD2_W),
        .PCNextW    (PCNextW),
        .RegWriteW  (RegWriteW),
        .MemReadW   (MemReadW),
        .MemWriteW  (MemWriteW),
        .Funct3W    (Funct3W),
        .ResultSrcW (ResultSrcW),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_a3      (rf_a3),
        .rf_wd      (rf_wd),
        .StallW     (StallW),
        .ErrW       (ErrW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: outcome of one W-stage memory instruction from the
    // access rules and the memory's grant/response delays.
    function automatic vec_t modelVec(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wd, input bit isLoad,
                                      input logic [4:0] a3, input logic [31:0] rdata,
                                      input int g, input int r);
        vec_t v;
        int n, off, wg, wr;
        bit bad, gTo, rTo;
        logic [31:0] mask, val;
        n   = 0;
        off = int'(addr[1:0]);
        case (f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        bad = (n == 0) || (n == 2 && (off % 2) != 0) || (n == 4 && off != 0);
        v.name = "RAND"; v.f3 = f3; v.addr = addr; v.wd = wd; v.isLoad = isLoad;
        v.a3 = a3; v.rdata = rdata; v.g = g; v.r = r;
        v.expBe    = bad ? 4'b0000 : 4'(((1 << n) - 1) << off);
        v.expWdata = (n == 1) ? wd[7:0] * 32'h01010101 :
                     (n == 2) ? wd[15:0] * 32'h00010001 : wd;
        mask = (n >= 4 || n == 0) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        val  = (rdata >> (8 * off)) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && val[8 * n - 1]) val = val | ~mask;
        gTo = (g > TO);
        wg  = gTo ? TO : g;
        rTo = 1'b0;
        wr  = 0;
        if (isLoad && !gTo) begin
            rTo = (r + 1 > TO);
            wr  = rTo ? TO : r + 1;
        end
        v.expStall = bad ? 0 : 1 + wg + wr;
        v.expReq   = bad ? 0 : 1 + wg;
        v.expErr   = bad || gTo || rTo;
        v.expRfWe  = isLoad && !v.expErr && (a3 != 5'd0);
        v.expRfWd  = val;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int  stallCnt, reqCnt, errEarly;
        bit  ended, noise;
        stallCnt = 0; reqCnt = 0; errEarly = 0; ended = 1'b0;
        noise = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        MemReadW   = v.isLoad;
        MemWriteW  = !v.isLoad;
        Funct3W    = v.f3;
        ALUResultW = v.addr;
        RD2_W      = v.wd;
        RegWriteW  = v.isLoad;
        A3_W       = v.a3;
        ResultSrcW = v.isLoad ? 2'b01 : 2'b00;
        PCNextW    = $urandom();
        for (int c = 0; c < 40; c++) begin
            mem_gnt    = (c == v.g);
            mem_rvalid = (v.isLoad && c == v.g + 1 + v.r) || (noise && c <= v.g);
            mem_rdata  = (v.isLoad && c == v.g + 1 + v.r) ? v.rdata : $urandom();
            @(negedge clk);
            if (c == 0 && v.expStall > 0) begin
                checkOutput({v.name, ".addr"}, mem_addr, {v.addr[31:2], 2'b00});
                checkOutput({v.name, ".be"}, 32'(mem_be), 32'(v.expBe));
                checkOutput({v.name, ".we"}, 32'(mem_we), 32'(!v.isLoad));
                if (!v.isLoad) checkOutput({v.name, ".wdata"}, mem_wdata, v.expWdata);
            end
            if (StallW) begin
                stallCnt++;
                if (mem_req) reqCnt++;
                if (ErrW) errEarly++;
            end else begin
                ended = 1'b1;
                checkOutput({v.name, ".err"}, 32'(ErrW), 32'(v.expErr));
                checkOutput({v.name, ".rfWe"}, 32'(rf_we), 32'(v.expRfWe));
                checkOutput({v.name, ".reqEnd"}, 32'(mem_req), 32'd0);
                if (v.expRfWe) begin
                    checkOutput({v.name, ".rfWd"}, rf_wd, v.expRfWd);
                    checkOutput({v.name, ".rfA3"}, 32'(rf_a3), 32'(v.a3));
                end
                break;
            end
            @(posedge clk); #1;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!ended) begin
            failures++;
            $display("[TB] FAIL %s.hang: got StallW stuck high expected release within 40 cycles", v.name);
        end
        checkOutput({v.name, ".stallCycles"}, 32'(stallCnt), 32'(v.expStall));
        checkOutput({v.name, ".reqCycles"}, 32'(reqCnt), 32'(v.expReq));
        checkOutput({v.name, ".errDuringStall"}, 32'(errEarly), 32'd0);
    endtask

    task automatic applyAlu(input string name, input logic [4:0] a3, input logic [31:0] alu,
                            input logic [31:0] pc, input logic [1:0] rs, input logic rw,
                            input logic expWe, input logic [31:0] expWd);
        MemReadW = 1'b0; MemWriteW = 1'b0; Funct3W = 3'b010;
        A3_W = a3; ALUResultW = alu; PCNextW = pc; ResultSrcW = rs; RegWriteW = rw;
        @(negedge clk);
        checkOutput({name, ".rfWe"}, 32'(rf_we), 32'(expWe));
        checkOutput({name, ".stall"}, 32'(StallW), 32'd0);
        checkOutput({name, ".req"}, 32'(mem_req), 32'd0);
        if (expWe) begin
            checkOutput({name, ".rfWd"}, rf_wd, expWd);
            checkOutput({name, ".rfA3"}, 32'(rf_a3), 32'(a3));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{"SB_103",  3'b000, 32'h103, 32'hAB,       1'b0, 5'd7, 32'h0,         0,  0, 1, 1, 4'b1000, 32'hABABABAB, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{"LB_102",  3'b000, 32'h102, 32'h0,        1'b1, 5'd7, 32'h0080_0000, 2,  0, 4, 3, 4'b0100, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{"LBU_102", 3'b100, 32'h102, 32'h0,        1'b1, 5'd7, 32'h0080_0000, 2,  0, 4, 3, 4'b0100, 32'h0,        1'b1, 32'h00000080, 1'b0};
        vecs[3]  = '{"LW_202",  3'b010, 32'h202, 32'h0,        1'b1, 5'd7, 32'h0,         0,  0, 0, 0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[4]  = '{"F3_011",  3'b011, 32'h200, 32'h0,        1'b1, 5'd7, 32'h0,         0,  0, 0, 0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[5]  = '{"LH_102",  3'b001, 32'h102, 32'h0,        1'b1, 5'd7, 32'h8001_0000, 0,  1, 3, 1, 4'b1100, 32'h0,        1'b1, 32'hFFFF8001, 1'b0};
        vecs[6]  = '{"LHU_102", 3'b101, 32'h102, 32'h0,        1'b1, 5'd7, 32'h8001_0000, 0,  1, 3, 1, 4'b1100, 32'h0,        1'b1, 32'h00008001, 1'b0};
        vecs[7]  = '{"SW_40",   3'b010, 32'h40,  32'hDEADBEEF, 1'b0, 5'd7, 32'h0,         1,  0, 2, 2, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[8]  = '{"SH_42",   3'b001, 32'h42,  32'h1234CAFE, 1'b0, 5'd7, 32'h0,         0,  0, 1, 1, 4'b1100, 32'hCAFECAFE, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{"LW_44",   3'b010, 32'h44,  32'h0,        1'b1, 5'd7, 32'h89ABCDEF,  0,  0, 2, 1, 4'b1111, 32'h0,        1'b1, 32'h89ABCDEF, 1'b0};
        vecs[10] = '{"LW_TMO",  3'b010, 32'h48,  32'h0,        1'b1, 5'd7, 32'h1,         0, 99, 5, 1, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[11] = '{"SW_GTMO", 3'b010, 32'h4C,  32'h5,        1'b0, 5'd7, 32'h0,        99,  0, 5, 5, 4'b1111, 32'h5,        1'b0, 32'h0,        1'b1};
        vecs[12] = '{"SH_101",  3'b001, 32'h101, 32'h0,        1'b0, 5'd7, 32'h0,         0,  0, 0, 0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[13] = '{"LB_103",  3'b000, 32'h103, 32'h0,        1'b1, 5'd7, 32'h7F00_0000, 0,  2, 4, 1, 4'b1000, 32'h0,        1'b1, 32'h0000007F, 1'b0};
        vecs[14] = '{"LW_A3Z",  3'b010, 32'h50,  32'h0,        1'b1, 5'd0, 32'h12345678,  0,  0, 2, 1, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b0};

        reset = 1'b1;
        A3_W = 5'd7; ALUResultW = 32'h40; RD2_W = 32'h0; PCNextW = 32'h0;
        RegWriteW = 1'b1; MemReadW = 1'b1; MemWriteW = 1'b0; Funct3W = 3'b010;
        ResultSrcW = 2'b01; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Outputs stay quiet while reset is held, even with a load presented.
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset.req", 32'(mem_req), 32'd0);
        checkOutput("reset.stall", 32'(StallW), 32'd0);
        checkOutput("reset.rfWe", 32'(rf_we), 32'd0);
        checkOutput("reset.err", 32'(ErrW), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        applyAlu("ALU_A3_5", 5'd5, 32'h1234, 32'h88, 2'b00, 1'b1, 1'b1, 32'h1234);
        applyAlu("ALU_A3_0", 5'd0, 32'h1234, 32'h88, 2'b00, 1'b1, 1'b0, 32'h0);
        applyAlu("JAL_LINK", 5'd1, 32'h1234, 32'h88, 2'b10, 1'b1, 1'b1, 32'h88);
        applyAlu("NO_WRITE", 5'd9, 32'h1234, 32'h88, 2'b00, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].expErr && vecs[i].expStall > 0) begin
                @(posedge clk); #1;
                MemReadW = 1'b0; MemWriteW = 1'b0; RegWriteW = 1'b0;
                @(negedge clk);
                checkOutput({vecs[i].name, ".errPulseEnd"}, 32'(ErrW), 32'd0);
                checkOutput({vecs[i].name, ".idleStall"}, 32'(StallW), 32'd0);
            end
        end

        // Reset while waiting for grant abandons the access.
        @(posedge clk); #1;
        MemReadW = 1'b1; MemWriteW = 1'b0; Funct3W = 3'b010; ALUResultW = 32'h40;
        RegWriteW = 1'b1; A3_W = 5'd7; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("rstSeq.reqIdle", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstSeq.stallWaitGnt", 32'(StallW), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstSeq.reqForced", 32'(mem_req), 32'd0);
        checkOutput("rstSeq.stallForced", 32'(StallW), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        applyAlu("rstSeq.afterIdle", 5'd3, 32'h55, 32'h0, 2'b00, 1'b1, 1'b1, 32'h55);
        applyStimulus(modelVec(3'b010, 32'h60, 32'h0, 1'b1, 5'd4, 32'hCAFEF00D, 0, 0));

        for (int i = 0; i < 40; i++) begin
            applyStimulus(modelVec(3'($urandom_range(0, 7)), $urandom(), $urandom(),
                                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                                   $urandom(), $urandom_range(0, 5), $urandom_range(0, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
